// File: rtl/sp_pkg.sv
// Shared definitions for the stack-pointer unit: state encoding, default
// parameters and the word-select width.
package sp_pkg;

    localparam int          SP_ADDR_W_DEF      = 32;
    localparam logic [31:0] SP_STACK_TOP_DEF   = 32'h0000_0FFF;
    localparam logic [31:0] SP_STACK_LIMIT_DEF = 32'h0000_0F00;
    localparam int          SP_ENTRY_WORDS_DEF = 2;

    localparam int WSEL_W = 2;

    localparam logic [1:0] SP_IDLE     = 2'd0;
    localparam logic [1:0] SP_PUSH_SEQ = 2'd1;
    localparam logic [1:0] SP_POP_SEQ  = 2'd2;

    typedef logic [WSEL_W-1:0] wsel_t;

    // Index of the final beat of an entry (N-1).
    function automatic wsel_t entry_last(input logic wide, input int entry_words);
        return wide ? wsel_t'(entry_words - 1) : '0;
    endfunction

endpackage

// File: rtl/sp_step_alu.sv
// +/-1 stack-pointer step and acceptance-time bound comparisons. The
// comparisons use one extra bit so they never wrap.
module sp_step_alu
    import sp_pkg::*;
#(
    parameter int                ADDR_W      = SP_ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STACK_TOP   = ADDR_W'(SP_STACK_TOP_DEF),
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(SP_STACK_LIMIT_DEF)
) (
    input  logic [ADDR_W-1:0] sp,
    input  wsel_t             last,
    output logic [ADDR_W-1:0] sp_inc,
    output logic [ADDR_W-1:0] sp_dec,
    output logic              push_oob,
    output logic              pop_oob
);

    localparam logic [ADDR_W:0] TOP_X   = {1'b0, STACK_TOP};
    localparam logic [ADDR_W:0] LIMIT_X = {1'b0, STACK_LIMIT};

    logic [ADDR_W:0] sp_x;
    logic [ADDR_W:0] last_x;

    assign sp_x   = {1'b0, sp};
    assign last_x = (ADDR_W+1)'(last);

    assign sp_inc = sp + ADDR_W'(1);
    assign sp_dec = sp - ADDR_W'(1);

    // Push occupies SP down to SP-(N-1); pop reaches up to SP+N.
    assign push_oob = (sp_x < (LIMIT_X + last_x)) || (sp_x > TOP_X);
    assign pop_oob  = (sp_x + last_x + (ADDR_W+1)'(1)) > TOP_X;

endmodule

// File: rtl/sp_unit.sv
// Stack-pointer unit: single/multi-word push and pop sequencing with a stall
// request. Optional stack bound checking is enabled by SP_BOUNDS_CHECK_EN.
module sp_unit
    import sp_pkg::*;
#(
    parameter int                ADDR_W      = SP_ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STACK_TOP   = ADDR_W'(SP_STACK_TOP_DEF),
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(SP_STACK_LIMIT_DEF),
    parameter int                ENTRY_WORDS = SP_ENTRY_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              PushSignal,
    input  logic              PopSignal,
    input  logic              Wide,
    output logic [ADDR_W-1:0] SPtoBuffer,
    output logic [WSEL_W-1:0] WordSel,
    output logic              AccessValid,
    output logic              Busy,
    output logic              Overflow,
    output logic              Underflow,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken in IDLE when Enable is high and exactly one
    // of PushSignal/PopSignal is set. While Busy is high the requester must hold
    // off; requests are ignored until the cycle after the beat with Busy low.

    logic [1:0]        state;
    logic [ADDR_W-1:0] sp;
    wsel_t             beat;
    wsel_t             last_q;

    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] sp_dec;
    logic              push_oob;
    logic              pop_oob;
    logic              req_one;
    logic              reject;
    logic              accept;
    wsel_t             req_last;

    logic              active;
    logic              is_push;
    wsel_t             cur_k;
    wsel_t             cur_last;

    assign req_one  = PushSignal ^ PopSignal;
    assign req_last = entry_last(Wide, ENTRY_WORDS);

    sp_step_alu #(
        .ADDR_W      (ADDR_W),
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_alu (
        .sp       (sp),
        .last     (req_last),
        .sp_inc   (sp_inc),
        .sp_dec   (sp_dec),
        .push_oob (push_oob),
        .pop_oob  (pop_oob)
    );

`ifdef SP_BOUNDS_CHECK_EN
    assign reject = PushSignal ? push_oob : pop_oob;
`else
    logic unused_bounds;
    assign unused_bounds = &{1'b0, push_oob, pop_oob};
    assign reject        = 1'b0;
`endif

    assign accept = !Reset && Enable && (state == SP_IDLE) && req_one && !reject;

    // Describe the beat on display: the new request in IDLE, otherwise the held
    // sequence beat (shown even while Enable is low).
    always_comb begin
        active   = 1'b0;
        is_push  = 1'b0;
        cur_k    = beat;
        cur_last = last_q;
        case (state)
            SP_IDLE: begin
                active   = accept;
                is_push  = PushSignal;
                cur_k    = '0;
                cur_last = req_last;
            end
            SP_PUSH_SEQ: begin
                active  = 1'b1;
                is_push = 1'b1;
            end
            SP_POP_SEQ: begin
                active  = 1'b1;
                is_push = 1'b0;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

    assign SPtoBuffer  = (active && !is_push) ? sp_inc : sp;
    assign WordSel     = !active ? '0 : (is_push ? cur_k : (cur_last - cur_k));
    assign AccessValid = active && Enable && !Reset;
    assign Busy        = active && !Reset && (cur_k != cur_last);
    assign dbg_state   = state;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= SP_IDLE;
            sp     <= STACK_TOP;
            beat   <= '0;
            last_q <= '0;
        end else if (Enable) begin
            case (state)
                SP_IDLE: begin
                    if (accept) begin
                        sp <= is_push ? sp_dec : sp_inc;
                        if (req_last != '0) begin
                            state  <= is_push ? SP_PUSH_SEQ : SP_POP_SEQ;
                            beat   <= wsel_t'(1);
                            last_q <= req_last;
                        end
                    end
                end
                SP_PUSH_SEQ, SP_POP_SEQ: begin
                    sp <= is_push ? sp_dec : sp_inc;
                    if (beat == last_q) begin
                        state <= SP_IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + wsel_t'(1);
                    end
                end
                default: begin
                    state <= SP_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

`ifdef SP_BOUNDS_CHECK_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (Enable && (state == SP_IDLE) && req_one && reject) begin
            if (PushSignal) overflow_q  <= 1'b1;
            else            underflow_q <= 1'b1;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

endmodule

// File: doc/sp_unit.md
# sp_unit

Parametrised stack-pointer unit for the memory stage of the RISC pipeline. It generates stack addresses for single-word and multi-word push/pop operations (CALL/RET/INT/RTI entries), sequences multi-word entries over consecutive cycles with a stall request, and optionally checks accesses against fixed stack bounds. It owns the SP register and drives the address to the memory buffer.

## Interface
- ADDR_W, 32: SP and address width.
- STACK_TOP, 32'h0000_0FFF: SP reset value; the highest stack word address. SP is never above STACK_TOP when the stack is empty.
- STACK_LIMIT, 32'h0000_0F00: lowest legal stack word address.
- ENTRY_WORDS, 2: number of words in a wide entry (2..4).
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  advance enable; low freezes all state.
- PushSignal  input  1  push request.
- PopSignal  input  1  pop request.
- Wide  input  1  the entry is ENTRY_WORDS words (0 = 1 word); sampled at acceptance.
- SPtoBuffer  output  ADDR_W  memory address for the current beat; equals SP when idle.
- WordSel  output  2  word of the entry being accessed this beat.
- AccessValid  output  1  the current beat performs a memory access.
- Busy  output  1  stall request; more beats follow the current one.
- Overflow  output  1  sticky push-bound violation (SP_BOUNDS_CHECK_EN only).
- Underflow  output  1  sticky pop-bound violation (SP_BOUNDS_CHECK_EN only).

## Operation
- The stack grows down. A push writes at SP and then decrements SP (post-decrement). A pop increments SP and then reads at the new SP (pre-increment).
- States:
  - IDLE: ready to accept a request.
  - PUSH_SEQ: continuing a multi-word push.
  - POP_SEQ: continuing a multi-word pop.
- Acceptance happens in IDLE when Enable=1 and exactly one of PushSignal/PopSignal is high. The entry length is N = Wide ? ENTRY_WORDS : 1.
- If PushSignal and PopSignal are both high, no operation occurs: SP is unchanged and AccessValid=0.
- Push beat k (k=0..N-1): SPtoBuffer=SP, WordSel=k, SP<=SP-1.
- Pop beat k: SPtoBuffer=SP+1, WordSel=N-1-k, SP<=SP+1. Pop therefore returns words in the reverse of push order, with matching WordSel.
- Beat 0 happens in the acceptance cycle.
  - If N>1, the unit enters PUSH_SEQ or POP_SEQ with an internal beat counter and returns to IDLE after beat N-1.
  - PushSignal, PopSignal and Wide are ignored outside IDLE.
- With Enable=0, state, SP and the beat counter hold; AccessValid=0; SPtoBuffer and WordSel show the held beat.
- Arithmetic is modulo 2^ADDR_W. With bounds checking compiled out, SP wraps silently.

## Timing
- SPtoBuffer, WordSel and AccessValid are combinational from state, SP and requests, so the address is valid in the request cycle (zero latency). SP updates at the end of each beat.
- Busy is high in every beat except beat N-1 of an entry. A wide push therefore asserts Busy for N-1 cycles and completes in N cycles.
- Reset (any time, including mid-sequence):
  - state = IDLE, SP = STACK_TOP, beat counter = 0;
  - Busy = 0, AccessValid = 0, WordSel = 0, SPtoBuffer = STACK_TOP;
  - Overflow = 0, Underflow = 0.
  - Partially transferred entries are abandoned.
- Back-to-back requests: a new request can be accepted in the cycle after the last beat.

## Configuration
- SP_BOUNDS_CHECK_EN defined:
  - Bounds are checked atomically at acceptance.
  - A push is rejected if SP-(N-1) < STACK_LIMIT or SP > STACK_TOP.
  - A pop is rejected if SP+N > STACK_TOP.
  - A rejected request performs no beats: AccessValid=0, Busy=0, SP unchanged, state stays IDLE.
  - A rejected push sets Overflow; a rejected pop sets Underflow. Both flags are sticky until Reset.
  - Comparisons are computed without modular wrap (one extra bit).
- SP_BOUNDS_CHECK_EN undefined: no checks are made, every request is accepted, and Overflow and Underflow are tied to 0.

## Structure
- Shared package sp_pkg holds:
  - the state encoding (SP_IDLE, SP_PUSH_SEQ, SP_POP_SEQ);
  - default parameter localparams;
  - the WordSel width constant.
- One sub-module, sp_step_alu: a parametrised ±1 step plus next-address/bound compare datapath.

## Test plan
All scenarios use defaults unless stated.
- Reset, then a single push (Wide=0) -> SPtoBuffer=0xFFF, AccessValid=1, Busy=0; next cycle SP=0xFFE.
- Wide push from SP=0xFFF -> beats at 0xFFF (WordSel 0, Busy 1) then 0xFFE (WordSel 1, Busy 0); SP=0xFFD. A following wide pop then reads 0xFFE (WordSel 1) then 0xFFF (WordSel 0), SP=0xFFF.
- Enable=0 for 3 cycles after beat 0 of a wide push -> SP and address hold at 0xFFE with AccessValid=0; the push resumes and completes when Enable=1.
- PushSignal=PopSignal=1 -> no access, SP unchanged.
- With SP_BOUNDS_CHECK_EN:
  - Pop at SP=0xFFF -> Underflow=1, SP stays 0xFFF.
  - Wide push at SP=0xF00 -> Overflow=1, no beats.
  - Without the macro, a pop at SP=0xFFF reads 0x1000.
- Reset asserted mid wide pop -> SP=0xFFF immediately, state IDLE, Busy=0.
